// File: rtl/gfx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gfx_pkg
//  Purpose  : Shared graphics definitions for the pixel output path.
//             RGB444 colour type, colour width, default transparent
//             palette index and the 4-to-8 bit channel expansion.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package gfx_pkg;

  localparam int COLR_BITS       = 12;
  localparam int TRANSP_IDX_DFLT = 0;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  // Bit replication maps 4'h0 -> 8'h00 and 4'hF -> 8'hFF exactly.
  function automatic logic [7:0] expand4to8(input logic [3:0] v);
    return {v, v};
  endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_compositor_if.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_compositor_if
//  Purpose  : Per-pixel bus from the sprite stages into the compositor.
//  Signals  : replay        synchronous clear of collision state/pipeline
//             frame         start-of-frame pulse
//             de            display enable for the current pixel
//             layer_pix     palette index per layer, layer k at [k*PIX_BITS+:PIX_BITS]
//             layer_colr    RGB444 per layer, layer k at [k*12+:12]
//             layer_drawing per-layer drawing flag
//             bg_colr       background RGB444
//  Modports : master (sprite stages drive), slave (compositor receives)
//  Revision : 1.0  initial release
// ============================================================================
interface sprite_compositor_if #(
  parameter int NLAYERS  = 4,
  parameter int PIX_BITS = 4
);
  import gfx_pkg::*;

  logic                          replay;
  logic                          frame;
  logic                          de;
  logic [NLAYERS*PIX_BITS-1:0]   layer_pix;
  logic [NLAYERS*COLR_BITS-1:0]  layer_colr;
  logic [NLAYERS-1:0]            layer_drawing;
  logic [COLR_BITS-1:0]          bg_colr;

  modport master (
    output replay, frame, de, layer_pix, layer_colr, layer_drawing, bg_colr
  );

  modport slave (
    input  replay, frame, de, layer_pix, layer_colr, layer_drawing, bg_colr
  );

endinterface
`default_nettype wire

// File: rtl/sprite_compositor_coll_counter.sv
`default_nettype none
// ============================================================================
//  Module   : coll_counter
//  Purpose  : Saturating 8-bit overlap counter with per-frame snapshot and
//             collision threshold compare.
//  Ports    : clk, i_rst_n   clock, async active-low reset
//             replay         sync clear of count and verdict
//             frame          snapshot and restart
//             ovl            one overlap pixel this cycle
//             collide        previous frame verdict (count >= COLL_MIN)
//             coll_count     previous frame count, saturated at 255
//  Revision : 1.0  initial release
// ============================================================================
module coll_counter #(
  parameter int COLL_MIN = 4
) (
  input  wire logic       clk,
  input  wire logic       i_rst_n,
  input  wire logic       replay,
  input  wire logic       frame,
  input  wire logic       ovl,
  output logic            collide,
  output logic [7:0]      coll_count
);

  localparam logic [7:0] COLL_MIN_C = 8'(COLL_MIN);

  logic [7:0] cnt;
  logic [7:0] cnt_inc;

  // Count including this cycle's overlap, so an overlap landing on the
  // frame pulse still belongs to the frame being closed.
  always_comb begin
    cnt_inc = cnt;
    if (ovl && (cnt != 8'hFF)) begin
      cnt_inc = cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt        <= 8'd0;
      collide    <= 1'b0;
      coll_count <= 8'd0;
    end else if (replay) begin
      cnt        <= 8'd0;
      collide    <= 1'b0;
      coll_count <= 8'd0;
    end else if (frame) begin
      coll_count <= cnt_inc;
      collide    <= (cnt_inc >= COLL_MIN_C);
      cnt        <= 8'd0;
    end else begin
      cnt        <= cnt_inc;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sprite_compositor.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_compositor
//  Purpose  : Picks the highest-priority opaque sprite layer over the
//             background and drives registered 8-bit RGB to the DAC, two
//             clocks after the inputs. Also reports per-frame player/monster
//             overlap for the game logic.
//  Ports    : clk, i_rst_n   pixel clock, async active-low reset
//             pix            sprite_compositor_if.slave pixel bus
//             o_r/o_g/o_b    8-bit DAC colour, zero while blanked
//             o_de           delayed display enable (blank_n)
//             collide        previous frame collision verdict
//             coll_count     previous frame overlap count (saturated)
//  Revision : 1.0  initial release
// ============================================================================
module sprite_compositor
  import gfx_pkg::*;
#(
  parameter int NLAYERS    = 4,
  parameter int PIX_BITS   = 4,
  parameter int TRANSP_IDX = TRANSP_IDX_DFLT,
  parameter int PLAYER_L   = 0,
  parameter int MONSTER_L  = 1,
  parameter int COLL_MIN   = 4
) (
  input  wire logic        clk,
  input  wire logic        i_rst_n,
  sprite_compositor_if.slave pix,
  output logic [7:0]       o_r,
  output logic [7:0]       o_g,
  output logic [7:0]       o_b,
  output logic             o_de,
  output logic             collide,
  output logic [7:0]       coll_count
);

  localparam logic [PIX_BITS-1:0] TRANSP_CODE = PIX_BITS'(TRANSP_IDX);

  logic [NLAYERS-1:0] opaque;
  rgb444_t            sel_next;
  logic               ovl_next;

  rgb444_t            sel_colr;
  logic               de_d1;
  logic               ovl_d1;

  for (genvar k = 0; k < NLAYERS; k++) begin : g_opaque
    assign opaque[k] = pix.layer_drawing[k] &&
                       (pix.layer_pix[k*PIX_BITS +: PIX_BITS] != TRANSP_CODE);
  end

  // Walk from lowest priority upward so the lowest-index opaque layer is
  // the last assignment and therefore wins.
  always_comb begin
    sel_next = rgb444_t'(pix.bg_colr);
    for (int k = NLAYERS - 1; k >= 0; k--) begin
      if (opaque[k]) begin
        sel_next = rgb444_t'(pix.layer_colr[k*COLR_BITS +: COLR_BITS]);
      end
    end
  end

  assign ovl_next = pix.de && opaque[PLAYER_L] && opaque[MONSTER_L];

  // Stage 1: selected colour and aligned enables.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sel_colr <= '0;
      de_d1    <= 1'b0;
      ovl_d1   <= 1'b0;
    end else if (pix.replay) begin
      sel_colr <= '0;
      de_d1    <= 1'b0;
      ovl_d1   <= 1'b0;
    end else begin
      sel_colr <= sel_next;
      de_d1    <= pix.de;
      ovl_d1   <= ovl_next;
    end
  end

  // Stage 2: DAC drive, forced black during blanking.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_r  <= 8'd0;
      o_g  <= 8'd0;
      o_b  <= 8'd0;
      o_de <= 1'b0;
    end else if (pix.replay) begin
      o_r  <= 8'd0;
      o_g  <= 8'd0;
      o_b  <= 8'd0;
      o_de <= 1'b0;
    end else begin
      o_r  <= de_d1 ? expand4to8(sel_colr.r) : 8'd0;
      o_g  <= de_d1 ? expand4to8(sel_colr.g) : 8'd0;
      o_b  <= de_d1 ? expand4to8(sel_colr.b) : 8'd0;
      o_de <= de_d1;
    end
  end

  coll_counter #(
    .COLL_MIN (COLL_MIN)
  ) u_coll_counter (
    .clk        (clk),
    .i_rst_n    (i_rst_n),
    .replay     (pix.replay),
    .frame      (pix.frame),
    .ovl        (ovl_d1),
    .collide    (collide),
    .coll_count (coll_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_sprite_compositor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sprite_compositor
//  Purpose  : Self-checking bench for sprite_compositor: directed scenarios
//             followed by random pixels, compared against a reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sprite_compositor;

  logic       clk = 1'b0;
  logic       i_rst_n;
  logic [7:0] o_r, o_g, o_b, coll_count;
  logic       o_de, collide;

  int checks   = 0;
  int failures = 0;

  sprite_compositor_if #(.NLAYERS(4), .PIX_BITS(4)) pix ();

  sprite_compositor #(
    .NLAYERS(4), .PIX_BITS(4), .TRANSP_IDX(0),
    .PLAYER_L(0), .MONSTER_L(1), .COLL_MIN(4)
  ) dut (
    .clk        (clk),
    .i_rst_n    (i_rst_n),
    .pix        (pix.slave),
    .o_r        (o_r),
    .o_g        (o_g),
    .o_b        (o_b),
    .o_de       (o_de),
    .collide    (collide),
    .coll_count (coll_count)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [11:0] m_s1_colr;
  logic        m_s1_de;
  logic        m_s1_ovl;
  logic [24:0] m_out;      // {de, r8, g8, b8}
  int          m_cnt;      // unbounded; saturation applied when reported
  logic        m_coll;
  int          m_cc;

  function automatic logic [11:0] ref_sel(input logic [15:0] lp, input logic [47:0] lc,
                                          input logic [3:0] dr, input logic [11:0] bg);
    for (int k = 0; k < 4; k++) begin
      if (dr[k] && lp[k*4 +: 4] != 4'd0) return lc[k*12 +: 12];
    end
    return bg;
  endfunction

  function automatic logic [24:0] dac(input logic d, input logic [11:0] c);
    int r, g, b;
    if (!d) return 25'd0;
    r = int'(c[11:8]) * 17;
    g = int'(c[7:4]) * 17;
    b = int'(c[3:0]) * 17;
    return {1'b1, r[7:0], g[7:0], b[7:0]};
  endfunction

  task automatic model_reset();
    m_s1_colr = '0; m_s1_de = 0; m_s1_ovl = 0;
    m_out = '0; m_cnt = 0; m_coll = 0; m_cc = 0;
  endtask

  task automatic model_edge();
    int v;
    if (pix.replay) begin
      model_reset();
      return;
    end
    m_out = dac(m_s1_de, m_s1_colr);
    v = m_cnt + (m_s1_ovl ? 1 : 0);
    if (pix.frame) begin
      m_cc   = (v > 255) ? 255 : v;
      m_coll = (m_cc >= 4);
      m_cnt  = 0;
    end else begin
      m_cnt  = v;
    end
    m_s1_colr = ref_sel(pix.layer_pix, pix.layer_colr, pix.layer_drawing, pix.bg_colr);
    m_s1_de   = pix.de;
    m_s1_ovl  = pix.de && pix.layer_drawing[0] && (pix.layer_pix[3:0] != 0) &&
                pix.layer_drawing[1] && (pix.layer_pix[7:4] != 0);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [7:0] cc8;
    cc8 = m_cc[7:0];
    chk("pixel", {7'd0, o_de, o_r, o_g, o_b}, {7'd0, m_out});
    chk("verdict", {23'd0, collide, coll_count}, {23'd0, m_coll, cc8});
  endtask

  task automatic step(input logic rp, input logic fr, input logic d,
                      input logic [15:0] lp, input logic [47:0] lc,
                      input logic [3:0] dr, input logic [11:0] bg);
    pix.replay = rp; pix.frame = fr; pix.de = d;
    pix.layer_pix = lp; pix.layer_colr = lc;
    pix.layer_drawing = dr; pix.bg_colr = bg;
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  // Layer setups: layers 0,1,2 colours F00 / 00F / 0F0, layer 3 FFF
  localparam logic [47:0] COLRS = {12'hFFF, 12'h0F0, 12'h00F, 12'hF00};
  localparam logic [15:0] PIX_ALL = 16'h1111;
  localparam logic [15:0] PIX_L1T = 16'h1101;   // layer 1 transparent
  localparam logic [15:0] PIX_L0T = 16'h1110;   // layer 0 transparent
  localparam logic [11:0] BG      = 12'h1A3;

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1, 16'h0, COLRS, 4'b0000, BG);
  endtask

  task automatic overlap(input int n, input logic d);
    for (int i = 0; i < n; i++) step(0, 0, d, PIX_ALL, COLRS, 4'b0011, BG);
  endtask

  initial begin
    i_rst_n = 1'b0;
    pix.replay = 0; pix.frame = 0; pix.de = 0;
    pix.layer_pix = '0; pix.layer_colr = '0; pix.layer_drawing = '0; pix.bg_colr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rgb", {8'd0, o_r, o_g, o_b}, 32'd0);
    chk("reset_flags", {22'd0, o_de, collide, coll_count}, 32'd0);
    @(negedge clk);
    i_rst_n = 1'b1;

    // Background only
    idle(3);
    chk("bg_only", {7'd0, o_de, o_r, o_g, o_b}, {7'd0, 1'b1, 24'h11AA33});

    // Priority: layers 0 and 2 opaque, layer 1 transparent
    repeat (3) step(0, 0, 1, PIX_L1T, COLRS, 4'b0101, BG);
    chk("prio_l0", {8'd0, o_r, o_g, o_b}, {8'd0, 24'hFF0000});
    repeat (3) step(0, 0, 1, PIX_L0T & PIX_L1T, COLRS, 4'b0101, BG);
    chk("prio_l2", {8'd0, o_r, o_g, o_b}, {8'd0, 24'h00FF00});

    // Blanking with opaque layers
    repeat (3) step(0, 0, 0, PIX_ALL, COLRS, 4'b1111, BG);
    chk("blank", {7'd0, o_de, o_r, o_g, o_b}, 32'd0);

    // Collision: 3 overlaps -> no verdict, 5 -> verdict, de=0 ignored
    step(0, 1, 1, 16'h0, COLRS, 4'b0000, BG);
    overlap(3, 1); idle(2);
    step(0, 1, 1, 16'h0, COLRS, 4'b0000, BG);
    chk("coll3", {23'd0, collide, coll_count}, {23'd0, 1'b0, 8'd3});
    overlap(5, 1); overlap(4, 0); idle(2);
    step(0, 1, 1, 16'h0, COLRS, 4'b0000, BG);
    chk("coll5", {23'd0, collide, coll_count}, {23'd0, 1'b1, 8'd5});

    // Saturation, last overlap lands on the frame pulse
    overlap(300, 1);
    step(0, 1, 1, 16'h0, COLRS, 4'b0000, BG);
    chk("sat", {23'd0, collide, coll_count}, {23'd0, 1'b1, 8'd255});
    idle(3);
    step(0, 1, 1, 16'h0, COLRS, 4'b0000, BG);
    chk("cnt_cleared", {23'd0, collide, coll_count}, 32'd0);

    // Replay wins over frame
    overlap(6, 1);
    step(0, 1, 1, 16'h0, COLRS, 4'b0000, BG);
    step(1, 1, 1, PIX_ALL, COLRS, 4'b0011, BG);
    chk("replay", {22'd0, o_de, collide, coll_count}, 32'd0);
    idle(3);

    // Async reset mid-line
    overlap(4, 1);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("async_rst", {o_de, collide, 6'd0, o_r, o_g, o_b}, 32'd0);
    chk("async_rst_cnt", {24'd0, coll_count}, 32'd0);
    model_reset();
    @(negedge clk);
    i_rst_n = 1'b1;

    // Random pixels against the model
    for (int i = 0; i < 600; i++) begin
      logic [15:0] lp;
      logic [47:0] lc;
      for (int k = 0; k < 4; k++)
        lp[k*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      lc = {16'($urandom), 32'($urandom)};
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 5) != 0), lp, lc, 4'($urandom), 12'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
